// File: rtl/mult8_seq_ctrl_if.sv
// Operand/result handshake and 4x4 core hookup for mult8_seq_ctrl.
// The slave modport is the controller; master is the producer/consumer/core side.
interface mult8_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_p;
    logic        busy;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, mul_p,
        output in_ready, out_valid, out_p, mul_a, mul_b, busy
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, mul_p,
        input  in_ready, out_valid, out_p, mul_a, mul_b, busy
    );
endinterface

// File: rtl/mult8_seq_ctrl.sv
// 8x8 unsigned multiply built from four passes through one external 4x4 core,
// accumulating the shifted partial products (LL, LH, HL, HH) into 16 bits.
module mult8_seq_ctrl #(
    parameter int MUL_LAT = 0   // 0: combinational core, 1: one register stage
) (
    input  logic              clk,
    input  logic              rst_n,
    mult8_seq_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    localparam logic [2:0] LAST_STEP = 3'(3 + MUL_LAT);

    state_e      state_q, state_d;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] out_q, out_d;
    logic [2:0]  step_q, step_d;
    logic [1:0]  cap_k;
    logic        cap_en;
    logic [15:0] term;
    logic [3:0]  mul_a_d, mul_b_d;

    // Partial product being captured lags the issued one by the core latency.
    assign cap_k  = step_q[1:0] - 2'(MUL_LAT);
    assign cap_en = (MUL_LAT == 0) ? 1'b1 : (step_q != 3'd0);

    always_comb begin
        term = {8'h00, bus.mul_p};
        case (cap_k)
            2'd0:    term = {8'h00, bus.mul_p};
            2'd3:    term = {bus.mul_p, 8'h00};
            default: term = {4'h0, bus.mul_p, 4'h0};
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        out_d   = out_q;
        step_d  = step_q;
        mul_a_d = 4'h0;
        mul_b_d = 4'h0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    acc_d   = 16'h0000;
                    step_d  = 3'd0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (step_q < 3'd4) begin
                    mul_a_d = step_q[1] ? a_q[7:4] : a_q[3:0];
                    mul_b_d = step_q[0] ? b_q[7:4] : b_q[3:0];
                end
                if (cap_en) acc_d = acc_q + term;
                step_d = step_q + 3'd1;
                if (step_q == LAST_STEP) begin
                    out_d   = acc_d;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            acc_q   <= 16'h0000;
            out_q   <= 16'h0000;
            step_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            step_q  <= step_d;
        end
    end

    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_p     = out_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.mul_a     = mul_a_d;
    assign bus.mul_b     = mul_b_d;
endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed and randomized checks of mult8_seq_ctrl with a combinational (u0)
// and a registered (u1) 4x4 core model.
module tb_mult8_seq_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    logic [15:0] last_p;

    always #5 clk = ~clk;

    mult8_seq_ctrl_if if0();
    mult8_seq_ctrl_if if1();

    mult8_seq_ctrl #(.MUL_LAT(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mult8_seq_ctrl #(.MUL_LAT(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    assign if0.mul_p = {4'h0, if0.mul_a} * {4'h0, if0.mul_b};
    always @(posedge clk) if1.mul_p <= {4'h0, if1.mul_a} * {4'h0, if1.mul_b};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge that starts an IDLE cycle; returns at the start
    // of the IDLE cycle following the output handshake.
    task automatic op0(input logic [7:0] a, input logic [7:0] b, input logic [31:0] nib,
                       input logic [15:0] exp, input int hold);
        if0.in_valid = 1'b1;
        if0.in_a = a;
        if0.in_b = b;
        @(negedge clk);
        chk("acc_rdy", if0.in_ready, 1);
        chk("idle_ov", if0.out_valid, 0);
        chk("idle_busy", if0.busy, 0);
        chk("hold_p", if0.out_p, last_p);
        nxt();
        if0.in_a = ~a;
        if0.in_b = ~b;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            chk("mul_nib", {if0.mul_a, if0.mul_b}, nib[31-8*s -: 8]);
            chk("calc_busy", if0.busy, 1);
            chk("calc_ov", if0.out_valid, 0);
            chk("calc_rdy", if0.in_ready, 0);
            nxt();
        end
        for (int h = 0; h <= hold; h++) begin
            if (h == hold) if0.out_ready = 1'b1;
            else if0.in_a = 8'h11 * 8'(h + 1);
            @(negedge clk);
            chk("done_ov", if0.out_valid, 1);
            chk("done_p", if0.out_p, exp);
            chk("done_rdy", if0.in_ready, 0);
            chk("done_busy", if0.busy, 1);
            nxt();
        end
        if0.out_ready = 1'b0;
        if0.in_valid = 1'b0;
        last_p = exp;
    endtask

    initial begin
        logic [15:0] q[$];
        logic [15:0] e;
        int sent, got, cyc, seen;
        bit acc;

        rst_n = 1'b0;
        last_p = 16'h0000;
        if0.in_valid = 0; if0.in_a = 0; if0.in_b = 0; if0.out_ready = 0;
        if1.in_valid = 0; if1.in_a = 0; if1.in_b = 0; if1.out_ready = 0;
        repeat (3) nxt();
        @(negedge clk);
        chk("rst_rdy", if0.in_ready, 0);
        chk("rst_ov", if0.out_valid, 0);
        chk("rst_p", if0.out_p, 0);
        chk("rst_busy", if0.busy, 0);
        chk("rst_mul", {if0.mul_a, if0.mul_b}, 0);
        nxt();
        rst_n = 1'b1;

        op0(8'hFF, 8'hFF, 32'hFF_FF_FF_FF, 16'hFE01, 0);
        op0(8'h12, 8'h34, 32'h24_23_14_13, 16'h03A8, 0);
        op0(8'h0B, 8'h0D, 32'hBD_B0_0D_00, 16'h008F, 3);
        op0(8'h05, 8'h06, 32'h56_50_06_00, 16'h001E, 0);

        // Abort in the second CALC cycle.
        if0.in_valid = 1'b1; if0.in_a = 8'h10; if0.in_b = 8'h10;
        nxt();
        if0.in_valid = 1'b0;
        nxt();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_rdy", if0.in_ready, 0);
        nxt();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rdy", if0.in_ready, 1);
        chk("rel_p", if0.out_p, 0);
        chk("rel_busy", if0.busy, 0);
        chk("rel_mul", {if0.mul_a, if0.mul_b}, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (if0.out_valid) seen++;
            nxt();
            @(negedge clk);
        end
        chk("rel_noval", seen, 0);
        nxt();
        last_p = 16'h0000;
        op0(8'h07, 8'h09, 32'h79_70_09_00, 16'h003F, 0);

        // Registered core: one extra CALC cycle.
        if1.in_valid = 1'b1; if1.in_a = 8'hA5; if1.in_b = 8'h3C;
        nxt();
        if1.in_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("l1_ov", if1.out_valid, 0);
            chk("l1_busy", if1.busy, 1);
            if (c == 5) chk("l1_mul4", {if1.mul_a, if1.mul_b}, 0);
            nxt();
        end
        @(negedge clk);
        chk("l1_ov6", if1.out_valid, 1);
        chk("l1_p", if1.out_p, 16'h26AC);
        nxt();
        if1.out_ready = 1'b1;
        nxt();
        if1.out_ready = 1'b0;
        @(negedge clk);
        chk("l1_idle", if1.in_ready, 1);

        // Random back-to-back with throttled consumer.
        nxt();
        sent = 0; got = 0; cyc = 0;
        if0.in_valid = 1'b1;
        if0.in_a = 8'($urandom);
        if0.in_b = 8'($urandom);
        if0.out_ready = 1'b1;
        while (got < 1000 && cyc < 40000) begin
            @(negedge clk);
            acc = 1'b0;
            if (if0.out_valid && if0.out_ready) begin
                if (q.size() == 0) chk("rnd_extra", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("rnd_p", if0.out_p, e);
                end
                got++;
            end
            if (if0.in_valid && if0.in_ready) begin
                q.push_back({8'h00, if0.in_a} * {8'h00, if0.in_b});
                sent++;
                acc = 1'b1;
            end
            nxt();
            cyc++;
            if (acc) begin
                if (sent < 1000) begin
                    if0.in_a = 8'($urandom);
                    if0.in_b = 8'($urandom);
                end else if0.in_valid = 1'b0;
            end
            if0.out_ready = ($urandom_range(0, 3) != 0);
        end
        chk("rnd_cnt", got, 1000);
        chk("rnd_left", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
